// File: rtl/bcd_to_decimal_decoder.sv
// ---------------------------------------------------------------------------
// bcd_to_decimal_decoder
//
// Streaming BCD-digit decoder. Each accepted digit produces one registered
// output beat carrying a one-hot decimal code. Digits are also accumulated,
// most-significant first, into a binary value until the digit flagged with
// in_last. Invalid codes (10..15) and numbers longer than DIGITS raise a
// sticky error that clears once the number's last beat has been formed.
//
// Optional feature macro: BCD_DEC_ACCUM_EN
//   defined   : accumulator, digit counter and over-length check present.
//   undefined : value tied to 0; error comes only from invalid codes.
//
// Parameters
//   DIGITS   maximum digits per number
//   VALUE_W  accumulator / value width (>= ceil(log2(10^DIGITS)))
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   in_valid/in_ready input handshake; bcd digit, in_last ends a number
//   out_valid/out_ready output handshake
//   dec               one-hot decimal code (all-zero on invalid code)
//   out_err           error flag for the current number (sticky)
//   out_last          copy of in_last for this beat
//   value             running value including this digit (0 on error)
// ---------------------------------------------------------------------------
module bcd_to_decimal_decoder #(
   parameter int DIGITS  = 4,
   parameter int VALUE_W = 14
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         bcd,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [9:0]         dec,
   output logic               out_err,
   output logic               out_last,
   output logic [VALUE_W-1:0] value
);

   if (DIGITS < 1 || VALUE_W < 1) begin : g_bad_params
      $error("bcd_to_decimal_decoder: DIGITS and VALUE_W must be >= 1");
   end

   typedef enum logic {ST_IDLE, ST_NUM} state_t;

   state_t     state_q, state_d;
   logic       err_q, err_d;
   logic       out_valid_q, out_valid_d;
   logic [9:0] dec_q, dec_d;
   logic       out_err_q, out_err_d;
   logic       out_last_q, out_last_d;

   logic       accept;
   logic       bad_code;
   logic       err_cur;
   logic       err_beat;
   logic [9:0] dec_code;

   // One-entry output register: a new digit can enter whenever the slot is
   // empty or is being drained in this same cycle.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign bad_code = (bcd > 4'd9);

   // Per-number state is only meaningful inside a number; in IDLE it reads 0.
   assign err_cur  = (state_q == ST_NUM) && err_q;

   always_comb begin
      dec_code = '0;
      if (!bad_code) dec_code[bcd] = 1'b1;
   end

`ifdef BCD_DEC_ACCUM_EN
   localparam int CNT_W = $clog2(DIGITS + 2);

   logic [VALUE_W-1:0] acc_q, acc_d, acc_cur, acc_next;
   logic [VALUE_W-1:0] value_q, value_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_cur, cnt_next;
   logic [CNT_W:0]     k;
   logic               over_len;

   assign acc_cur  = (state_q == ST_NUM) ? acc_q : '0;
   assign cnt_cur  = (state_q == ST_NUM) ? cnt_q : '0;
   // k is the 1-based position of the incoming digit; one extra bit so the
   // saturated count plus one never wraps.
   assign k        = {1'b0, cnt_cur} + (CNT_W+1)'(1);
   assign over_len = (k > (CNT_W+1)'(DIGITS));
   // Over-length and invalid digits leave the accumulator untouched; the
   // beat value is forced to 0 by the error anyway.
   assign acc_next = (over_len || bad_code) ? acc_cur
                   : acc_cur * VALUE_W'(10) + VALUE_W'(bcd);
   assign cnt_next = (k > (CNT_W+1)'(DIGITS + 1)) ? CNT_W'(DIGITS + 1)
                   : k[CNT_W-1:0];
   assign err_beat = err_cur | bad_code | over_len;
   assign value    = value_q;
`else
   assign err_beat = err_cur | bad_code;
   assign value    = '0;
`endif

   always_comb begin
      state_d     = state_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      dec_d       = dec_q;
      out_err_d   = out_err_q;
      out_last_d  = out_last_q;
`ifdef BCD_DEC_ACCUM_EN
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      value_d     = value_q;
`endif
      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (accept) begin
         // Load overrides the drain above: old beat leaves, new beat lands.
         out_valid_d = 1'b1;
         dec_d       = dec_code;
         out_err_d   = err_beat;
         out_last_d  = in_last;
`ifdef BCD_DEC_ACCUM_EN
         value_d     = err_beat ? '0 : acc_next;
`endif
         if (in_last) begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
`ifdef BCD_DEC_ACCUM_EN
            acc_d   = '0;
            cnt_d   = '0;
`endif
         end else begin
            state_d = ST_NUM;
            err_d   = err_beat;
`ifdef BCD_DEC_ACCUM_EN
            acc_d   = acc_next;
            cnt_d   = cnt_next;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         dec_q       <= '0;
         out_err_q   <= 1'b0;
         out_last_q  <= 1'b0;
`ifdef BCD_DEC_ACCUM_EN
         acc_q       <= '0;
         cnt_q       <= '0;
         value_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         dec_q       <= dec_d;
         out_err_q   <= out_err_d;
         out_last_q  <= out_last_d;
`ifdef BCD_DEC_ACCUM_EN
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         value_q     <= value_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign dec       = dec_q;
   assign out_err   = out_err_q;
   assign out_last  = out_last_q;

endmodule
